mc_control_fsm: RTL
===================

Name: mc_control_fsm

Overview:
Parametrised multicycle MIPS control FSM; next generation of the 8-bit multicycle control unit.
- Generalises the instruction fetch to IR_BYTES byte-wide fetch cycles.
- Adds a memory ready/wait handshake, a bne/j mode, full funct decode and an illegal-opcode flag.
- Sits between the IR opcode/funct fields and the datapath muxes/enables; state is also exported one-hot for debug.

Parameters:
IR_BYTES, 4, number of byte fetch cycles per instruction (1..8); width of IRWr
EN_BNE, 1, 1 = decode bne (opcode 000101); 0 = treat as illegal
EN_JUMP, 1, 1 = decode j (opcode 000010); 0 = treat as illegal
N_STATES, 12, one-hot state vector width (fixed by package; exposed for S_out sizing)

Ports:
Fclk  in  1  system clock, rising edge
ResetBar  in  1  asynchronous, active-low reset
OP  in  6  IR opcode field
F  in  6  IR funct field
Zero_DetectBar  in  1  ALU zero flag, active-low (0 = result zero)
mem_ready  in  1  memory completes current access this cycle
MemRead  out  1  memory read request
MemWrite  out  1  memory write strobe
IorD  out  1  0 = PC address, 1 = ALUOut address
IRWr  out  IR_BYTES  one-hot IR byte write enable
PCWrite  out  1  PC load
PCSrc  out  2  00 ALU, 01 ALUOut, 10 jump target
ALUSrcA  out  1  0 = PC, 1 = reg A
ALUSrcB  out  2  00 B, 01 const 1, 10 imm, 11 imm shifted
ALUCont  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
RegWrite  out  1  register file write
RegDst  out  1  1 = rd, 0 = rt
MemtoReg  out  1  1 = MDR to register file
S_out  out  N_STATES  one-hot current state
illegal_op  out  1  sticky illegal opcode/funct flag

Behaviour:
- States: FETCH, DECODE, MEMADR, LBRD, LBWR, SBWR, RTEX, RTWR, ADDIEX, ADDIWR, BREX, JEX.
- Byte counter fb: 0..IR_BYTES-1.
- Reset (ResetBar=0, async):
  - state = FETCH, fb = 0, illegal_op = 0.
  - All outputs forced 0 while ResetBar=0, except S_out = FETCH bit.
- Outputs are Moore, decoded from the state register.
  - MemWrite, IRWr, the fetch PCWrite and the branch PCWrite are additionally qualified as specified per state.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUCont=010, PCSrc=00.
  - IRWr[fb]=mem_ready; PCWrite=mem_ready.
  - On mem_ready: if fb<IR_BYTES-1 then fb++ and stay in FETCH; else fb=0 and go to DECODE.
  - No mem_ready: hold, all strobes 0.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUCont=010. Next state by OP:
  - 100000 lb or 101000 sb -> MEMADR
  - 000000 -> RTEX
  - 001000 -> ADDIEX
  - 000100, or 000101 when EN_BNE -> BREX
  - 000010 when EN_JUMP -> JEX
  - other -> FETCH with illegal_op set
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUCont=010. lb -> LBRD; sb -> SBWR.
- LBRD: MemRead=1, IorD=1. Held until mem_ready, then -> LBWR.
- LBWR: RegWrite=1, RegDst=0, MemtoReg=1. -> FETCH.
- SBWR: IorD=1, MemWrite=mem_ready. Held until mem_ready, then -> FETCH.
- RTEX: ALUSrcA=1, ALUSrcB=00. ALUCont from F:
  - 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
  - Unknown F: illegal_op set, next state FETCH (RTWR skipped).
- RTWR: RegWrite=1, RegDst=1, MemtoReg=0. -> FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUCont=010. -> ADDIWR.
- ADDIWR: RegWrite=1, RegDst=0. -> FETCH.
- BREX: ALUSrcA=1, ALUSrcB=00, ALUCont=110, PCSrc=01.
  - PCWrite = beq ? ~Zero_DetectBar : Zero_DetectBar (bne).
  - -> FETCH.
- JEX: PCSrc=10, PCWrite=1. -> FETCH.
- Opcode and funct are sampled combinationally in the state that uses them. The IR is stable after the last fetch byte.
- illegal_op:
  - Sticky; cleared only by reset.
  - Set on the clock edge leaving DECODE (illegal OP) or leaving RTEX (illegal F).
- Reset mid-access, including mid-fetch or while waiting in LBRD/SBWR: immediate return to FETCH with fb=0. No strobe pulse is produced.
- mem_ready outside FETCH/LBRD/SBWR is ignored.
- Exactly one S_out bit is high at all times.

Decomposition:
- Package mc_ctrl_pkg:
  - state enum and one-hot index constants
  - opcode constants (OP_RTYPE, OP_LB, OP_SB, OP_ADDI, OP_BEQ, OP_BNE, OP_J)
  - funct constants
  - ALUCont encodings
  - ALUSrcB and PCSrc encodings
- Sub-module alu_funct_dec: F -> ALUCont plus funct_valid. Purely combinational; also reused by the datapath test bench.

Test Plan:
- add, IR_BYTES=4, mem_ready=1 always, OP=000000, F=100000:
  - IRWr sequence 0001, 0010, 0100, 1000, each with PCWrite=1.
  - Then DECODE, RTEX (ALUCont=010), RTWR (RegWrite=1, RegDst=1).
  - FETCH on cycle 8.
- lb with mem_ready low 3 cycles in LBRD:
  - MemRead=1, IorD=1 held 4 cycles.
  - Then LBWR with MemtoReg=1, RegWrite=1.
- Branches:
  - beq with Zero_DetectBar=0 -> PCWrite=1, PCSrc=01 in BREX.
  - bne with Zero_DetectBar=0 -> PCWrite=0.
  - EN_BNE=0, OP=000101 -> illegal_op=1, back to FETCH.
- sb with mem_ready low in SBWR: MemWrite=0 until the mem_ready cycle, single 1-cycle MemWrite pulse.
- ResetBar asserted during the third fetch byte: outputs 0 immediately; after release fetch restarts with IRWr=0001.
- R-type with F=111111 -> ALU still in RTEX, no RegWrite, illegal_op=1 and remains 1 through subsequent valid instructions.

Source files
------------

// File: rtl/mc_control_fsm_pkg.sv
// Shared definitions for the multicycle MIPS control unit: FSM state
// encoding, opcode/funct field values and datapath mux select encodings.
package mc_ctrl_pkg;

  // Number of FSM states. This also sets the width of the one-hot debug vector.
  localparam int unsigned N_ST = 12;

  // Each enum value is also the bit index of that state in the one-hot S_out vector.
  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_LBRD   = 4'd3,
    ST_LBWR   = 4'd4,
    ST_SBWR   = 4'd5,
    ST_RTEX   = 4'd6,
    ST_RTWR   = 4'd7,
    ST_ADDIEX = 4'd8,
    ST_ADDIWR = 4'd9,
    ST_BREX   = 4'd10,
    ST_JEX    = 4'd11
  } state_t;

  // Opcode field values
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct field values
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALUCont encodings
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALUSrcB encodings
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_ONE   = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // PCSrc encodings
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic [N_ST-1:0] state_onehot(input state_t s);
    return N_ST'(1) << s;
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Bundle of signals between the control FSM and the datapath/memory.
//   master : control FSM side. It reads the IR fields, the zero flag and
//            mem_ready, and it drives the mux selects, enables and debug state.
//   slave  : datapath/memory side, with the directions reversed.
interface mc_control_fsm_if
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned IR_BYTES = 4,
  parameter int unsigned N_STATES = N_ST
);
  logic [5:0]          OP;
  logic [5:0]          F;
  logic                Zero_DetectBar;
  logic                mem_ready;
  logic                MemRead;
  logic                MemWrite;
  logic                IorD;
  logic [IR_BYTES-1:0] IRWr;
  logic                PCWrite;
  logic [1:0]          PCSrc;
  logic                ALUSrcA;
  logic [1:0]          ALUSrcB;
  logic [2:0]          ALUCont;
  logic                RegWrite;
  logic                RegDst;
  logic                MemtoReg;
  logic [N_STATES-1:0] S_out;
  logic                illegal_op;

  modport master (
    input  OP, F, Zero_DetectBar, mem_ready,
    output MemRead, MemWrite, IorD, IRWr, PCWrite, PCSrc, ALUSrcA, ALUSrcB,
           ALUCont, RegWrite, RegDst, MemtoReg, S_out, illegal_op
  );

  modport slave (
    output OP, F, Zero_DetectBar, mem_ready,
    input  MemRead, MemWrite, IorD, IRWr, PCWrite, PCSrc, ALUSrcA, ALUSrcB,
           ALUCont, RegWrite, RegDst, MemtoReg, S_out, illegal_op
  );
endinterface

// File: rtl/mc_control_fsm_alu_funct_dec.sv
// R-type funct decoder. It maps F to an ALUCont value and flags unknown
// funct codes. The block is purely combinational.
//   F           in  6  IR funct field
//   ALUCont     out 3  ALU operation. Defaults to add when F is unknown.
//   funct_valid out 1  1 = F is a supported R-type funct
module alu_funct_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] F,
  output logic [2:0] ALUCont,
  output logic       funct_valid
);
  always_comb begin
    ALUCont     = ALU_ADD;
    funct_valid = 1'b1;
    case (F)
      FN_ADD:  ALUCont = ALU_ADD;
      FN_SUB:  ALUCont = ALU_SUB;
      FN_AND:  ALUCont = ALU_AND;
      FN_OR:   ALUCont = ALU_OR;
      FN_SLT:  ALUCont = ALU_SLT;
      default: funct_valid = 1'b0;
    endcase
  end
endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control FSM. Fetches the instruction in IR_BYTES
// byte-wide cycles, waits on mem_ready in the fetch and memory states, and
// decodes lb/sb/R-type/addi/beq plus optional bne/j. Unsupported opcodes and
// funct codes set a sticky illegal_op flag.
//   Fclk     in  1  clock, rising edge
//   ResetBar in  1  asynchronous active-low reset. All outputs read 0 while
//                   it is low, except S_out, which shows FETCH.
//   bus      master modport of mc_control_fsm_if. It carries the IR fields,
//                   the zero flag, mem_ready and all datapath controls.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned IR_BYTES = 4,
  parameter int unsigned EN_BNE   = 1,
  parameter int unsigned EN_JUMP  = 1,
  parameter int unsigned N_STATES = N_ST
)(
  input  logic           Fclk,
  input  logic           ResetBar,
  mc_control_fsm_if.master bus
);
  localparam int unsigned     FBW     = (IR_BYTES > 1) ? $clog2(IR_BYTES) : 1;
  localparam logic [FBW-1:0]  FB_LAST = FBW'(IR_BYTES - 1);

  state_t         r_state, w_state_nxt;
  logic [FBW-1:0] r_fb, w_fb_nxt;
  logic           r_illegal, w_illegal_set;

  logic [2:0]          w_rt_alu;
  logic                w_funct_ok;
  logic                w_memread, w_memwrite, w_iord, w_pcwrite;
  logic                w_alusrca, w_regwrite, w_regdst, w_memtoreg;
  logic [1:0]          w_pcsrc, w_alusrcb;
  logic [2:0]          w_alucont;
  logic [IR_BYTES-1:0] w_irwr;

  alu_funct_dec u_funct_dec (
    .F           (bus.F),
    .ALUCont     (w_rt_alu),
    .funct_valid (w_funct_ok)
  );

  // State register, fetch byte counter and the sticky illegal flag
  always_ff @(posedge Fclk or negedge ResetBar) begin
    if (!ResetBar) begin
      r_state   <= ST_FETCH;
      r_fb      <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_fb    <= w_fb_nxt;
      if (w_illegal_set)
        r_illegal <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt   = r_state;
    w_fb_nxt      = r_fb;
    w_illegal_set = 1'b0;
    unique case (r_state)
      ST_FETCH:
        if (bus.mem_ready) begin
          if (r_fb == FB_LAST) begin
            w_fb_nxt    = '0;
            w_state_nxt = ST_DECODE;
          end else begin
            w_fb_nxt = r_fb + 1'b1;
          end
        end
      ST_DECODE:
        if (bus.OP == OP_LB || bus.OP == OP_SB)
          w_state_nxt = ST_MEMADR;
        else if (bus.OP == OP_RTYPE)
          w_state_nxt = ST_RTEX;
        else if (bus.OP == OP_ADDI)
          w_state_nxt = ST_ADDIEX;
        else if (bus.OP == OP_BEQ || (EN_BNE != 0 && bus.OP == OP_BNE))
          w_state_nxt = ST_BREX;
        else if (EN_JUMP != 0 && bus.OP == OP_J)
          w_state_nxt = ST_JEX;
        else begin
          w_state_nxt   = ST_FETCH;
          w_illegal_set = 1'b1;
        end
      ST_MEMADR: w_state_nxt = (bus.OP == OP_SB) ? ST_SBWR : ST_LBRD;
      ST_LBRD:   if (bus.mem_ready) w_state_nxt = ST_LBWR;
      ST_LBWR:   w_state_nxt = ST_FETCH;
      ST_SBWR:   if (bus.mem_ready) w_state_nxt = ST_FETCH;
      ST_RTEX:
        if (w_funct_ok)
          w_state_nxt = ST_RTWR;
        else begin
          w_state_nxt   = ST_FETCH;
          w_illegal_set = 1'b1;
        end
      ST_RTWR:   w_state_nxt = ST_FETCH;
      ST_ADDIEX: w_state_nxt = ST_ADDIWR;
      ST_ADDIWR: w_state_nxt = ST_FETCH;
      ST_BREX:   w_state_nxt = ST_FETCH;
      ST_JEX:    w_state_nxt = ST_FETCH;
      default:   w_state_nxt = ST_FETCH;
    endcase
  end

  // Moore outputs. Gating with ResetBar keeps the FETCH strobes quiet while
  // reset is held, because the state register already reads FETCH then.
  always_comb begin
    w_memread  = 1'b0;
    w_memwrite = 1'b0;
    w_iord     = 1'b0;
    w_irwr     = '0;
    w_pcwrite  = 1'b0;
    w_pcsrc    = PCSRC_ALU;
    w_alusrca  = 1'b0;
    w_alusrcb  = SRCB_B;
    w_alucont  = 3'b000;
    w_regwrite = 1'b0;
    w_regdst   = 1'b0;
    w_memtoreg = 1'b0;
    if (ResetBar) begin
      unique case (r_state)
        ST_FETCH: begin
          w_memread = 1'b1;
          w_alusrcb = SRCB_ONE;
          w_alucont = ALU_ADD;
          w_irwr    = IR_BYTES'(bus.mem_ready) << r_fb;
          w_pcwrite = bus.mem_ready;
        end
        ST_DECODE: begin
          w_alusrcb = SRCB_IMMSH;
          w_alucont = ALU_ADD;
        end
        ST_MEMADR, ST_ADDIEX: begin
          w_alusrca = 1'b1;
          w_alusrcb = SRCB_IMM;
          w_alucont = ALU_ADD;
        end
        ST_LBRD: begin
          w_memread = 1'b1;
          w_iord    = 1'b1;
        end
        ST_LBWR: begin
          w_regwrite = 1'b1;
          w_memtoreg = 1'b1;
        end
        ST_SBWR: begin
          w_iord     = 1'b1;
          w_memwrite = bus.mem_ready;
        end
        ST_RTEX: begin
          w_alusrca = 1'b1;
          w_alusrcb = SRCB_B;
          w_alucont = w_rt_alu;
        end
        ST_RTWR: begin
          w_regwrite = 1'b1;
          w_regdst   = 1'b1;
        end
        ST_ADDIWR: w_regwrite = 1'b1;
        ST_BREX: begin
          w_alusrca = 1'b1;
          w_alusrcb = SRCB_B;
          w_alucont = ALU_SUB;
          w_pcsrc   = PCSRC_ALUOUT;
          w_pcwrite = (bus.OP == OP_BEQ) ? ~bus.Zero_DetectBar : bus.Zero_DetectBar;
        end
        ST_JEX: begin
          w_pcsrc   = PCSRC_JUMP;
          w_pcwrite = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.MemRead    = w_memread;
  assign bus.MemWrite   = w_memwrite;
  assign bus.IorD       = w_iord;
  assign bus.IRWr       = w_irwr;
  assign bus.PCWrite    = w_pcwrite;
  assign bus.PCSrc      = w_pcsrc;
  assign bus.ALUSrcA    = w_alusrca;
  assign bus.ALUSrcB    = w_alusrcb;
  assign bus.ALUCont    = w_alucont;
  assign bus.RegWrite   = w_regwrite;
  assign bus.RegDst     = w_regdst;
  assign bus.MemtoReg   = w_memtoreg;
  assign bus.S_out      = N_STATES'(state_onehot(r_state));
  assign bus.illegal_op = r_illegal;
endmodule
